// File: rtl/display_seven_seg.sv
// display_seven_seg: single-digit 7-segment driver for a 3-digit display.
// Decodes a hex nibble to segments a..g plus decimal point and selects one
// of three digit enables. Both output buses are registered (1-cycle latency).
module display_seven_seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dp_in,
    input  logic [1:0] en_in,
    input  logic [3:0] display_in,
    output logic [7:0] segment_out,
    output logic [2:0] enable_out
);

    // Blank values: every segment off, no digit enabled, in output polarity.
    localparam logic [7:0] SEG_BLANK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [2:0] EN_BLANK  = EN_ACTIVE_LOW  ? 3'b111 : 3'b000;

    logic [6:0] glyph;      // lit = 1, bits g..a
    logic [7:0] seg_lit;    // lit = 1, dp in bit 7
    logic [2:0] en_lit;     // enabled = 1
    logic [7:0] seg_next;
    logic [2:0] en_next;

    // Hex nibble to active-high segment pattern.
    always_comb begin
        glyph = '0;
        unique case (display_in)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
        endcase
    end

    // Digit select and blanking, then apply output polarity per bus.
    always_comb begin
        seg_lit = {dp_in, glyph};
        en_lit  = '0;
        unique case (en_in)
            2'd0: en_lit = 3'b001;
            2'd1: en_lit = 3'b010;
            2'd2: en_lit = 3'b100;
            2'd3: begin
                en_lit  = '0;
                seg_lit = '0;   // index 3 blanks segments regardless of value/dp
            end
        endcase
        seg_next = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
        en_next  = EN_ACTIVE_LOW  ? ~en_lit  : en_lit;
    end

    // Output registers; reset blanks the display and has priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            segment_out <= SEG_BLANK;
            enable_out  <= EN_BLANK;
        end else begin
            segment_out <= seg_next;
            enable_out  <= en_next;
        end
    end

endmodule

// File: tb/tb_display_seven_seg.sv
// Directed bench for display_seven_seg: default-polarity instance plus an
// instance with both polarities inverted, checked against hand tables.
module tb_display_seven_seg;

    logic       clock;
    logic       reset;
    logic       dp_in;
    logic [1:0] en_in;
    logic [3:0] display_in;
    logic [7:0] segment_out;
    logic [2:0] enable_out;
    logic [7:0] segment_out_inv;
    logic [2:0] enable_out_inv;

    int checks = 0;
    int errors = 0;

    // Active-low segment codes for 0..F, dp off.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    // Active-low digit enables for en_in 0..3.
    logic [2:0] en_tab [4] = '{3'b110, 3'b101, 3'b011, 3'b111};

    display_seven_seg dut (
        .clock       (clock),
        .reset       (reset),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .display_in  (display_in),
        .segment_out (segment_out),
        .enable_out  (enable_out)
    );

    display_seven_seg #(
        .SEG_ACTIVE_LOW (1'b0),
        .EN_ACTIVE_LOW  (1'b0)
    ) dut_inv (
        .clock       (clock),
        .reset       (reset),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .display_in  (display_in),
        .segment_out (segment_out_inv),
        .enable_out  (enable_out_inv)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; dp_in = 1'b1; en_in = 2'd2; display_in = 4'hA;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hFF, 3'b111}) begin
            errors++;
            $display("FAIL reset_default: got %h/%b expected ff/111", segment_out, enable_out);
        end
        checks++;
        if ({segment_out_inv, enable_out_inv} !== {8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_inverted: got %h/%b expected 00/000", segment_out_inv, enable_out_inv);
        end
        reset = 1'b0; dp_in = 1'b0; en_in = 2'd0; display_in = 4'h0;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hC0, 3'b110}) begin
            errors++;
            $display("FAIL reset_release: got %h/%b expected c0/110", segment_out, enable_out);
        end
    endtask

    task automatic test_hex_sweep();
        en_in = 2'd0; dp_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            display_in = i[3:0];
            tick();
            checks++;
            if ({segment_out, enable_out} !== {seg_tab[i], 3'b110}) begin
                errors++;
                $display("FAIL hex_sweep[%0d]: got %h/%b expected %h/110",
                         i, segment_out, enable_out, seg_tab[i]);
            end
            checks++;
            if ({segment_out_inv, enable_out_inv} !== {~seg_tab[i], 3'b001}) begin
                errors++;
                $display("FAIL hex_sweep_inv[%0d]: got %h/%b expected %h/001",
                         i, segment_out_inv, enable_out_inv, ~seg_tab[i]);
            end
        end
    endtask

    task automatic test_enable_sweep();
        logic [7:0] exp_seg;
        display_in = 4'h8; dp_in = 1'b0;
        for (int e = 0; e < 4; e++) begin
            en_in = e[1:0];
            exp_seg = (e == 3) ? 8'hFF : 8'h80;
            tick();
            checks++;
            if ({segment_out, enable_out} !== {exp_seg, en_tab[e]}) begin
                errors++;
                $display("FAIL enable_sweep[%0d]: got %h/%b expected %h/%b",
                         e, segment_out, enable_out, exp_seg, en_tab[e]);
            end
            checks++;
            if ({segment_out_inv, enable_out_inv} !== {~exp_seg, ~en_tab[e]}) begin
                errors++;
                $display("FAIL enable_sweep_inv[%0d]: got %h/%b expected %h/%b",
                         e, segment_out_inv, enable_out_inv, ~exp_seg, ~en_tab[e]);
            end
        end
    endtask

    task automatic test_decimal_point();
        dp_in = 1'b1; en_in = 2'd1; display_in = 4'h5;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'h12, 3'b101}) begin
            errors++;
            $display("FAIL dp_digit1: got %h/%b expected 12/101", segment_out, enable_out);
        end
        checks++;
        if (segment_out_inv !== 8'hED) begin
            errors++;
            $display("FAIL dp_digit1_inv: got %h expected ed", segment_out_inv);
        end
        en_in = 2'd3;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hFF, 3'b111}) begin
            errors++;
            $display("FAIL dp_blank: got %h/%b expected ff/111", segment_out, enable_out);
        end
        en_in = 2'd0; display_in = 4'h0;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'h40, 3'b110}) begin
            errors++;
            $display("FAIL dp_zero: got %h/%b expected 40/110", segment_out, enable_out);
        end
        dp_in = 1'b0;
    endtask

    task automatic test_wrap();
        en_in = 2'd2; dp_in = 1'b0; display_in = 4'hF;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'h8E, 3'b011}) begin
            errors++;
            $display("FAIL wrap_f: got %h/%b expected 8e/011", segment_out, enable_out);
        end
        display_in = 4'h0;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hC0, 3'b011}) begin
            errors++;
            $display("FAIL wrap_0: got %h/%b expected c0/011", segment_out, enable_out);
        end
    endtask

    task automatic test_back_to_back();
        // All three inputs change on the same edge.
        dp_in = 1'b1; en_in = 2'd0; display_in = 4'hB;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'h03, 3'b110}) begin
            errors++;
            $display("FAIL b2b_first: got %h/%b expected 03/110", segment_out, enable_out);
        end
        dp_in = 1'b0; en_in = 2'd2; display_in = 4'hD;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hA1, 3'b011}) begin
            errors++;
            $display("FAIL b2b_second: got %h/%b expected a1/011", segment_out, enable_out);
        end
    endtask

    task automatic test_mid_reset();
        dp_in = 1'b0; en_in = 2'd1; display_in = 4'h7;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hF8, 3'b101}) begin
            errors++;
            $display("FAIL mid_reset_pre: got %h/%b expected f8/101", segment_out, enable_out);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hFF, 3'b111}) begin
            errors++;
            $display("FAIL mid_reset_blank: got %h/%b expected ff/111", segment_out, enable_out);
        end
        checks++;
        if ({segment_out_inv, enable_out_inv} !== {8'h00, 3'b000}) begin
            errors++;
            $display("FAIL mid_reset_blank_inv: got %h/%b expected 00/000", segment_out_inv, enable_out_inv);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({segment_out, enable_out} !== {8'hF8, 3'b101}) begin
            errors++;
            $display("FAIL mid_reset_resume: got %h/%b expected f8/101", segment_out, enable_out);
        end
    endtask

    initial begin
        reset = 1'b0; dp_in = 1'b0; en_in = 2'd0; display_in = 4'h0;
        #2;
        test_reset();
        test_hex_sweep();
        test_enable_sweep();
        test_decimal_point();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
